// File: rtl/cplx_mult_pipe.sv
// rtl/cplx_mult_pipe.sv - pipelined signed complex multiplier with rescale and saturation
// Fixed latency of STAGES clocks from a fired operand pair to its valid result.
module cplx_mult_pipe #(
  parameter int OPERAND_WIDTH_A   = 16,
  parameter int OPERAND_WIDTH_B   = 16,
  parameter int OPERAND_WIDTH_OUT = 16,
  parameter int STAGES            = 6,
  parameter int BLOCKING          = 0,
  parameter int GROWTH_BITS       = 0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [2*OPERAND_WIDTH_A-1:0]     s_axis_a_tdata,
  input  logic                             s_axis_a_tvalid,
  input  logic [2*OPERAND_WIDTH_B-1:0]     s_axis_b_tdata,
  input  logic                             s_axis_b_tvalid,
  output logic [2*OPERAND_WIDTH_OUT-1:0]   m_axis_dout_tdata,
  output logic                             m_axis_dout_tvalid
);

  localparam int WA  = OPERAND_WIDTH_A;
  localparam int WB  = OPERAND_WIDTH_B;
  localparam int WO  = OPERAND_WIDTH_OUT;
  localparam int FW  = WA + WB + 1;
  localparam int SH  = FW - WO + GROWTH_BITS;
  localparam int SHR = (SH > 0) ? SH : 0;
  localparam int SHL = (SH < 0) ? -SH : 0;
  localparam int XW  = FW + SHL;
  localparam int CW  = XW + WO + 1;

  localparam logic signed [CW-1:0] SAT_MAX = {{(CW-WO+1){1'b0}}, {(WO-1){1'b1}}};
  localparam logic signed [CW-1:0] SAT_MIN = {{(CW-WO+1){1'b1}}, {(WO-1){1'b0}}};

  logic              fire;
  logic [2*WA-1:0]   a_sel;
  logic [2*WB-1:0]   b_sel;

  generate
    if (BLOCKING != 0) begin : g_blocking
      logic            pend_a;
      logic            pend_b;
      logic [2*WA-1:0] hold_a;
      logic [2*WB-1:0] hold_b;

      // A fresh arrival always takes priority over the held copy (newest wins).
      assign fire  = (s_axis_a_tvalid | pend_a) & (s_axis_b_tvalid | pend_b);
      assign a_sel = s_axis_a_tvalid ? s_axis_a_tdata : hold_a;
      assign b_sel = s_axis_b_tvalid ? s_axis_b_tdata : hold_b;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          pend_a <= 1'b0;
          pend_b <= 1'b0;
          hold_a <= '0;
          hold_b <= '0;
        end else if (fire) begin
          pend_a <= 1'b0;
          pend_b <= 1'b0;
        end else begin
          if (s_axis_a_tvalid) begin
            pend_a <= 1'b1;
            hold_a <= s_axis_a_tdata;
          end
          if (s_axis_b_tvalid) begin
            pend_b <= 1'b1;
            hold_b <= s_axis_b_tdata;
          end
        end
      end
    end else begin : g_paired
      assign fire  = s_axis_a_tvalid & s_axis_b_tvalid;
      assign a_sel = s_axis_a_tdata;
      assign b_sel = s_axis_b_tdata;
    end
  endgenerate

  logic [2*WA-1:0]   a_s1;
  logic [2*WB-1:0]   b_s1;
  logic [STAGES-1:0] vld_sr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_s1   <= '0;
      b_s1   <= '0;
      vld_sr <= '0;
    end else begin
      if (fire) begin
        a_s1 <= a_sel;
        b_s1 <= b_sel;
      end
      vld_sr <= {vld_sr[STAGES-2:0], fire};
    end
  end

  logic signed [FW-1:0] ar, ai, br, bi;
  logic signed [FW-1:0] re_full, im_full;

  // Operands are widened to the full product width so the sums stay exact.
  assign ar = FW'($signed(a_s1[WA-1:0]));
  assign ai = FW'($signed(a_s1[2*WA-1:WA]));
  assign br = FW'($signed(b_s1[WB-1:0]));
  assign bi = FW'($signed(b_s1[2*WB-1:WB]));

  assign re_full = ar * br - ai * bi;
  assign im_full = ar * bi + ai * br;

  function automatic logic [WO-1:0] rescale(input logic signed [FW-1:0] v);
    logic signed [XW-1:0] x;
    logic signed [CW-1:0] w;
    x = XW'(v);
    x = (x >>> SHR) <<< SHL;
    w = CW'(x);
    if (w > SAT_MAX) begin
      rescale = SAT_MAX[WO-1:0];
    end else if (w < SAT_MIN) begin
      rescale = SAT_MIN[WO-1:0];
    end else begin
      rescale = w[WO-1:0];
    end
  endfunction

  logic [2*WO-1:0] res_pipe [0:STAGES-2];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES - 1; i++) begin
        res_pipe[i] <= '0;
      end
    end else begin
      res_pipe[0] <= {rescale(im_full), rescale(re_full)};
      for (int i = 1; i < STAGES - 1; i++) begin
        res_pipe[i] <= res_pipe[i-1];
      end
    end
  end

  assign m_axis_dout_tdata  = res_pipe[STAGES-2];
  assign m_axis_dout_tvalid = vld_sr[STAGES-1];

endmodule

// File: tb/tb_cplx_mult_pipe.sv
// tb/tb_cplx_mult_pipe.sv - bench for cplx_mult_pipe, paired and blocking variants
module tb_cplx_mult_pipe;

  localparam int WA = 8;
  localparam int WB = 8;
  localparam int WO = 8;
  localparam int ST = 6;
  localparam int GB = -2;
  localparam int SH = WA + WB + 1 - WO + GB;
  localparam int N  = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a_data, b_data;
  logic        a_valid, b_valid;
  logic [15:0] d0, d1;
  logic        v0, v1;

  always #5 clk = ~clk;

  cplx_mult_pipe #(
    .OPERAND_WIDTH_A(WA), .OPERAND_WIDTH_B(WB), .OPERAND_WIDTH_OUT(WO),
    .STAGES(ST), .BLOCKING(0), .GROWTH_BITS(GB)
  ) dut0 (
    .clk_i(clk), .rst_i(rst),
    .s_axis_a_tdata(a_data), .s_axis_a_tvalid(a_valid),
    .s_axis_b_tdata(b_data), .s_axis_b_tvalid(b_valid),
    .m_axis_dout_tdata(d0), .m_axis_dout_tvalid(v0)
  );

  cplx_mult_pipe #(
    .OPERAND_WIDTH_A(WA), .OPERAND_WIDTH_B(WB), .OPERAND_WIDTH_OUT(WO),
    .STAGES(ST), .BLOCKING(1), .GROWTH_BITS(GB)
  ) dut1 (
    .clk_i(clk), .rst_i(rst),
    .s_axis_a_tdata(a_data), .s_axis_a_tvalid(a_valid),
    .s_axis_b_tdata(b_data), .s_axis_b_tvalid(b_valid),
    .m_axis_dout_tdata(d1), .m_axis_dout_tvalid(v1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        obs_v0 [0:N-1];
  logic        obs_v1 [0:N-1];
  logic [15:0] obs_d0 [0:N-1];
  logic [15:0] obs_d1 [0:N-1];
  bit          exp_v0 [0:N-1];
  bit          exp_v1 [0:N-1];
  logic [15:0] exp_d0 [0:N-1];
  logic [15:0] exp_d1 [0:N-1];

  always @(negedge clk) begin
    if (cyc < N) begin
      obs_v0[cyc] = v0;
      obs_v1[cyc] = v1;
      obs_d0[cyc] = d0;
      obs_d1[cyc] = d1;
    end
  end

  bit          pa, pb;
  logic [15:0] ha, hb;
  int          total = 0;
  int          bad = 0;

  function automatic logic [7:0] sat_part(input int full);
    int s;
    s = full >>> SH;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s[7:0];
  endfunction

  function automatic logic [15:0] ref_mult(input logic [15:0] a, input logic [15:0] b);
    int ar, ai, br, bi;
    ar = $signed(a[7:0]);
    ai = $signed(a[15:8]);
    br = $signed(b[7:0]);
    bi = $signed(b[15:8]);
    return {sat_part(ar * bi + ai * br), sat_part(ar * br - ai * bi)};
  endfunction

  // Drives one cycle of stimulus and records what each variant should emit ST cycles later.
  task automatic drive(input logic r, input logic av, input logic [15:0] a,
                       input logic bv, input logic [15:0] b);
    int c;
    @(posedge clk);
    #1;
    c = cyc;
    rst = r; a_valid = av; a_data = a; b_valid = bv; b_data = b;
    if (r) begin
      for (int k = c + 1; k <= c + ST && k < N; k++) begin
        exp_v0[k] = 1'b0;
        exp_v1[k] = 1'b0;
      end
      pa = 1'b0;
      pb = 1'b0;
    end else if (c + ST < N) begin
      if (av && bv) begin
        exp_v0[c+ST] = 1'b1;
        exp_d0[c+ST] = ref_mult(a, b);
      end
      if ((av || pa) && (bv || pb)) begin
        exp_v1[c+ST] = 1'b1;
        exp_d1[c+ST] = ref_mult(av ? a : ha, bv ? b : hb);
        pa = 1'b0;
        pb = 1'b0;
      end else begin
        if (av) begin pa = 1'b1; ha = a; end
        if (bv) begin pb = 1'b1; hb = b; end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic test_reset;
    int t0;
    t0 = cyc + 1;
    repeat (3) drive(1'b1, 1'b1, 16'h1234, 1'b1, 16'h5678);
    idle(3);
    for (int c = t0 + 1; c <= t0 + 4; c++) begin
      total++;
      if (obs_v0[c] !== 1'b0 || obs_d0[c] !== 16'h0 || obs_v1[c] !== 1'b0 || obs_d1[c] !== 16'h0) begin
        bad++;
        $display("FAIL reset cyc=%0d got v0=%b d0=%h v1=%b d1=%h want all zero",
                 c - t0, obs_v0[c], obs_d0[c], obs_v1[c], obs_d1[c]);
      end
    end
  endtask

  task automatic test_single;
    int t0;
    t0 = cyc + 1;
    drive(1'b0, 1'b1, 16'h0040, 1'b1, 16'h007F);
    idle(9);
    for (int k = 1; k <= 7; k++) begin
      total++;
      if (obs_v0[t0+k] !== (k == ST) || obs_v1[t0+k] !== (k == ST)) begin
        bad++;
        $display("FAIL single_valid k=%0d got v0=%b v1=%b want %b", k, obs_v0[t0+k], obs_v1[t0+k], k == ST);
      end
    end
    total++;
    if (obs_d0[t0+ST] !== 16'h003F || obs_d1[t0+ST] !== 16'h003F) begin
      bad++;
      $display("FAIL single_data got d0=%h d1=%h want 003f", obs_d0[t0+ST], obs_d1[t0+ST]);
    end
  endtask

  task automatic test_directed;
    int          t0;
    logic [15:0] ea [0:2];
    ea[0] = 16'h00E0;
    ea[1] = 16'h0040;
    ea[2] = 16'h017F;
    t0 = cyc + 1;
    drive(1'b0, 1'b1, 16'h4000, 1'b1, 16'h4000);
    drive(1'b0, 1'b1, 16'h4040, 1'b1, 16'hC040);
    drive(1'b0, 1'b1, 16'h8080, 1'b1, 16'h7F80);
    idle(9);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_v0[t0+ST+k] !== 1'b1 || obs_d0[t0+ST+k] !== ea[k] ||
          obs_v1[t0+ST+k] !== 1'b1 || obs_d1[t0+ST+k] !== ea[k]) begin
        bad++;
        $display("FAIL directed k=%0d got v0=%b d0=%h v1=%b d1=%h want v=1 d=%h",
                 k, obs_v0[t0+ST+k], obs_d0[t0+ST+k], obs_v1[t0+ST+k], obs_d1[t0+ST+k], ea[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int          t0;
    logic [15:0] want;
    t0 = cyc + 1;
    for (int k = 0; k < 16; k++) drive(1'b0, 1'b1, 16'(k), 1'b1, 16'h007F);
    idle(9);
    for (int k = 0; k <= 16; k++) begin
      want = (k < 16) ? 16'((127 * k) / 128) : 16'h0;
      total++;
      if (obs_v0[t0+ST+k] !== (k < 16) || obs_v1[t0+ST+k] !== (k < 16) ||
          (k < 16 && (obs_d0[t0+ST+k] !== want || obs_d1[t0+ST+k] !== want))) begin
        bad++;
        $display("FAIL stream k=%0d got v0=%b d0=%h v1=%b d1=%h want v=%b d=%h",
                 k, obs_v0[t0+ST+k], obs_d0[t0+ST+k], obs_v1[t0+ST+k], obs_d1[t0+ST+k], k < 16, want);
      end
    end
  endtask

  task automatic test_lone_valid;
    int t0;
    drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    t0 = cyc + 1;
    drive(1'b0, 1'b1, 16'h0040, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h007F);
    idle(10);
    for (int k = 0; k <= 10; k++) begin
      total++;
      if (obs_v0[t0+k] !== 1'b0 || obs_v1[t0+k] !== (k == ST + 1)) begin
        bad++;
        $display("FAIL lone_valid k=%0d got v0=%b v1=%b want v0=0 v1=%b", k, obs_v0[t0+k], obs_v1[t0+k], k == ST + 1);
      end
    end
    total++;
    if (obs_d1[t0+ST+1] !== 16'h003F) begin
      bad++;
      $display("FAIL lone_data got d1=%h want 003f", obs_d1[t0+ST+1]);
    end
  endtask

  task automatic test_reset_mid;
    int t0;
    t0 = cyc + 1;
    drive(1'b0, 1'b1, 16'h0040, 1'b1, 16'h007F);
    drive(1'b0, 1'b1, 16'h0041, 1'b1, 16'h007F);
    drive(1'b1, 1'b1, 16'h0042, 1'b1, 16'h007F);
    drive(1'b1, 1'b1, 16'h0043, 1'b1, 16'h007F);
    idle(9);
    drive(1'b0, 1'b1, 16'h4040, 1'b1, 16'hC040);
    idle(8);
    for (int k = 0; k <= 12; k++) begin
      total++;
      if (obs_v0[t0+k] !== 1'b0 || obs_v1[t0+k] !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid k=%0d got v0=%b v1=%b want 0", k, obs_v0[t0+k], obs_v1[t0+k]);
      end
    end
    total++;
    if (obs_d0[t0+3] !== 16'h0 || obs_d1[t0+3] !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid_data got d0=%h d1=%h want 0000", obs_d0[t0+3], obs_d1[t0+3]);
    end
    total++;
    if (obs_v0[t0+13+ST] !== 1'b1 || obs_d0[t0+13+ST] !== 16'h0040 ||
        obs_v1[t0+13+ST] !== 1'b1 || obs_d1[t0+13+ST] !== 16'h0040) begin
      bad++;
      $display("FAIL post_reset got v0=%b d0=%h v1=%b d1=%h want v=1 d=0040",
               obs_v0[t0+13+ST], obs_d0[t0+13+ST], obs_v1[t0+13+ST], obs_d1[t0+13+ST]);
    end
  endtask

  task automatic test_random;
    int t0;
    t0 = cyc + 1;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, 16'($urandom),
            $urandom_range(0, 3) != 0, 16'($urandom));
    end
    idle(ST + 2);
    for (int c = t0 + ST; c < cyc; c++) begin
      total++;
      if (obs_v0[c] !== exp_v0[c] || (exp_v0[c] && obs_d0[c] !== exp_d0[c])) begin
        bad++;
        $display("FAIL random_b0 cyc=%0d got v=%b d=%h want v=%b d=%h", c, obs_v0[c], obs_d0[c], exp_v0[c], exp_d0[c]);
      end
      total++;
      if (obs_v1[c] !== exp_v1[c] || (exp_v1[c] && obs_d1[c] !== exp_d1[c])) begin
        bad++;
        $display("FAIL random_b1 cyc=%0d got v=%b d=%h want v=%b d=%h", c, obs_v1[c], obs_d1[c], exp_v1[c], exp_d1[c]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    pa = 1'b0; pb = 1'b0; ha = '0; hb = '0;
    test_reset;
    test_single;
    test_directed;
    test_back_to_back;
    test_lone_valid;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
